// File: rtl/ch_list_merge_if.sv
// Shared-memory and control bundle for the cluster-head list merger.
// The master side is the merger; the slave side is the memory/controller.
interface ch_list_merge_if #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 11
);
    logic              en;
    logic              start;
    logic [WORD_W-1:0] data_in;
    logic [ADDR_W-1:0] address;
    logic              wr_en;
    logic [WORD_W-1:0] data_out;
    logic              busy;
    logic              done;
    logic              overflow;

    modport master (
        input  en, start, data_in,
        output address, wr_en, data_out, busy, done, overflow
    );

    modport slave (
        output en, start, data_in,
        input  address, wr_en, data_out, busy, done, overflow
    );
endinterface

// File: rtl/ch_list_merge.sv
// Merges every known cluster-head ID into each neighbour's chIDs list held in shared memory,
// appending missing IDs and writing back the list count; raises a sticky overflow on full lists.
module ch_list_merge #(
    parameter int WORD_W    = 16,
    parameter int ADDR_W    = 11,
    parameter int MAX_CH    = 8,
    parameter int MAX_NB    = 16,
    parameter int NCNT_ADDR = 'h274,
    parameter int KCNT_ADDR = 'h272,
    parameter int KCH_BASE  = 'h012,
    parameter int CCNT_BASE = 'h278,
    parameter int CID_BASE  = 'h172,
    parameter int NB_STRIDE = 16
) (
    input  logic                 clock,
    input  logic                 nrst,
    ch_list_merge_if.master      bus_io
);
    localparam int NCNT_W = $clog2(MAX_NB + 1);
    localparam int IDX_W  = (MAX_NB > 1) ? $clog2(MAX_NB) : 1;
    localparam int CCNT_W = $clog2(MAX_CH + 1);
    localparam int K_W    = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
    localparam int JX_W   = WORD_W + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_L_NCNT, S_L_KCNT, S_L_KCH, S_L_CCNT,
        S_L_CID, S_APPEND, S_WR_CNT, S_NEXT, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic                wr_en_q, wr_en_d;
    logic [WORD_W-1:0]   data_out_q, data_out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;
    logic [NCNT_W-1:0]   ncnt_q, ncnt_d;
    logic [WORD_W-1:0]   kcnt_q, kcnt_d;
    logic [WORD_W-1:0]   kch_q, kch_d;
    logic [CCNT_W-1:0]   ccnt_q, ccnt_d;
    logic [IDX_W-1:0]    i_q, i_d;
    logic [WORD_W-1:0]   j_q, j_d;
    logic [K_W-1:0]      k_q, k_d;

    logic [NCNT_W-1:0]   ncnt_in;
    logic [CCNT_W-1:0]   ccnt_in;

    // All address arithmetic wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] wrap_addr(input int a);
        logic [31:0] u;
        u = a;
        return u[ADDR_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] cid_addr(input int i, input int k);
        return wrap_addr(CID_BASE + NB_STRIDE * i + 2 * k);
    endfunction

    function automatic logic [ADDR_W-1:0] ccnt_addr(input int i);
        return wrap_addr(CCNT_BASE + 2 * i);
    endfunction

    function automatic logic [ADDR_W-1:0] kch_addr(input int j);
        return wrap_addr(KCH_BASE + 2 * j);
    endfunction

    always_comb begin
        ncnt_in = (bus_io.data_in > WORD_W'(MAX_NB)) ? NCNT_W'(MAX_NB) : bus_io.data_in[NCNT_W-1:0];
        ccnt_in = (bus_io.data_in > WORD_W'(MAX_CH)) ? CCNT_W'(MAX_CH) : bus_io.data_in[CCNT_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        address_d  = address_q;
        wr_en_d    = 1'b0;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        ncnt_d     = ncnt_q;
        kcnt_d     = kcnt_q;
        kch_d      = kch_q;
        ccnt_d     = ccnt_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;

        // Dropping enable abandons the walk; overflow and completed writes are kept.
        if (state_q != S_IDLE && !bus_io.en) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus_io.en && bus_io.start) begin
                        busy_d     = 1'b1;
                        overflow_d = 1'b0;
                        i_d        = '0;
                        j_d        = '0;
                        k_d        = '0;
                        address_d  = wrap_addr(NCNT_ADDR);
                        state_d    = S_L_NCNT;
                    end
                end
                S_L_NCNT: begin
                    ncnt_d    = ncnt_in;
                    address_d = wrap_addr(KCNT_ADDR);
                    state_d   = S_L_KCNT;
                end
                S_L_KCNT: begin
                    kcnt_d = bus_io.data_in;
                    if (ncnt_q == '0 || bus_io.data_in == '0) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        address_d = kch_addr(0);
                        state_d   = S_L_KCH;
                    end
                end
                S_L_KCH: begin
                    kch_d     = bus_io.data_in;
                    i_d       = '0;
                    address_d = ccnt_addr(0);
                    state_d   = S_L_CCNT;
                end
                S_L_CCNT: begin
                    ccnt_d = ccnt_in;
                    k_d    = '0;
                    if (ccnt_in == '0) begin
                        state_d = S_APPEND;
                    end else begin
                        address_d = cid_addr(int'(i_q), 0);
                        state_d   = S_L_CID;
                    end
                end
                S_L_CID: begin
                    if (bus_io.data_in == kch_q) begin
                        state_d = S_NEXT;
                    end else if (CCNT_W'(k_q) + CCNT_W'(1) == ccnt_q) begin
                        state_d = S_APPEND;
                    end else begin
                        k_d       = k_q + K_W'(1);
                        address_d = address_q + ADDR_W'(2);
                    end
                end
                S_APPEND: begin
                    if (ccnt_q >= CCNT_W'(MAX_CH)) begin
                        overflow_d = 1'b1;
                        state_d    = S_NEXT;
                    end else begin
                        address_d  = cid_addr(int'(i_q), int'(ccnt_q));
                        data_out_d = kch_q;
                        wr_en_d    = 1'b1;
                        state_d    = S_WR_CNT;
                    end
                end
                S_WR_CNT: begin
                    address_d  = ccnt_addr(int'(i_q));
                    data_out_d = WORD_W'(ccnt_q) + WORD_W'(1);
                    wr_en_d    = 1'b1;
                    state_d    = S_NEXT;
                end
                S_NEXT: begin
                    if (NCNT_W'(i_q) + NCNT_W'(1) < ncnt_q) begin
                        i_d       = i_q + IDX_W'(1);
                        address_d = ccnt_addr(int'(i_q) + 1);
                        state_d   = S_L_CCNT;
                    end else if (JX_W'(j_q) + JX_W'(1) < JX_W'(kcnt_q)) begin
                        j_d       = j_q + WORD_W'(1);
                        address_d = kch_addr(int'(j_q) + 1);
                        state_d   = S_L_KCH;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            address_q  <= '0;
            wr_en_q    <= 1'b0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            ncnt_q     <= '0;
            kcnt_q     <= '0;
            kch_q      <= '0;
            ccnt_q     <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
        end else begin
            state_q    <= state_d;
            address_q  <= address_d;
            wr_en_q    <= wr_en_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            ncnt_q     <= ncnt_d;
            kcnt_q     <= kcnt_d;
            kch_q      <= kch_d;
            ccnt_q     <= ccnt_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
        end
    end

    assign bus_io.address  = address_q;
    assign bus_io.wr_en    = wr_en_q;
    assign bus_io.data_out = data_out_q;
    assign bus_io.busy     = busy_q;
    assign bus_io.done     = done_q;
    assign bus_io.overflow = overflow_q;

endmodule

// File: tb/tb_ch_list_merge.sv
// Randomised scoreboard bench for ch_list_merge: a list-level reference model predicts every
// memory write, the done latency and the overflow flag; a negedge monitor checks DUT activity.
module tb_ch_list_merge;
    localparam int WORD_W    = 16;
    localparam int ADDR_W    = 11;
    localparam int MAX_CH    = 8;
    localparam int MAX_NB    = 16;
    localparam int NCNT_ADDR = 'h274;
    localparam int KCNT_ADDR = 'h272;
    localparam int KCH_BASE  = 'h012;
    localparam int CCNT_BASE = 'h278;
    localparam int CID_BASE  = 'h172;
    localparam int NB_STRIDE = 16;
    localparam int MEM_N     = 1 << ADDR_W;

    logic clock = 1'b0;
    logic nrst  = 1'b0;
    always #5 clock = ~clock;

    ch_list_merge_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

    ch_list_merge #(
        .WORD_W(WORD_W), .ADDR_W(ADDR_W), .MAX_CH(MAX_CH), .MAX_NB(MAX_NB),
        .NCNT_ADDR(NCNT_ADDR), .KCNT_ADDR(KCNT_ADDR), .KCH_BASE(KCH_BASE),
        .CCNT_BASE(CCNT_BASE), .CID_BASE(CID_BASE), .NB_STRIDE(NB_STRIDE)
    ) dut (
        .clock (clock),
        .nrst  (nrst),
        .bus_io(bus)
    );

    // Memory: combinational read of the registered address, write at the clock edge.
    logic [15:0] mem [MEM_N];
    logic [15:0] img [MEM_N];
    logic [15:0] mm  [MEM_N];
    logic        load_req = 1'b0;

    always @(posedge clock) begin
        if (load_req) begin
            for (int a = 0; a < MEM_N; a++) mem[a] <= img[a];
        end else if (bus.wr_en === 1'b1) begin
            mem[bus.address] <= bus.data_out;
        end
    end
    assign bus.data_in = mem[bus.address];

    typedef struct {
        bit is_done;
        int addr;
        int data;
        bit ovf;
        int lat;
    } exp_t;
    exp_t sb[$];

    int checks     = 0;
    int errors     = 0;
    int cyc_cnt    = 0;
    int start_mark = 0;
    int done_count = 0;

    int c_ncnt, c_kcnt;
    int c_kch [4];
    int c_cnt [MAX_NB];
    int c_list[MAX_NB][MAX_CH];

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    function automatic int ad(input int a);
        return a & (MEM_N - 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
        else $display("ok   %s: 0x%0h", name, act);
    endtask

    // Monitor: every write and every done pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (nrst === 1'b1) begin
            if (bus.wr_en === 1'b1) begin
                if (sb.size() == 0 || sb[0].is_done) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                             bus.address, bus.data_out);
                end else begin
                    e = sb.pop_front();
                    check("write_addr", int'(bus.address), e.addr);
                    check("write_data", int'(bus.data_out), e.data);
                end
            end
            if (bus.done === 1'b1) begin
                done_count++;
                if (sb.size() == 0 || !sb[0].is_done) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done pulsed with %0d writes still pending", sb.size());
                end else begin
                    e = sb.pop_front();
                    check("done_overflow", int'(bus.overflow), int'(e.ovf));
                    check("done_latency", cyc_cnt - start_mark, e.lat);
                    check("done_busy_low", int'(bus.busy), 0);
                end
            end
        end
    end

    // List-level reference: for each known CH, for each neighbour, append if absent and room.
    task automatic model_push();
        int n, kc, cyc, c, exam, kch, la, ca;
        bit found, ovf;
        exp_t e;
        for (int a = 0; a < MEM_N; a++) mm[a] = img[a];
        n = int'(mm[NCNT_ADDR]);
        if (n > MAX_NB) n = MAX_NB;
        kc  = int'(mm[KCNT_ADDR]);
        cyc = 2;
        ovf = 1'b0;
        if (n != 0 && kc != 0) begin
            for (int j = 0; j < kc; j++) begin
                kch = int'(mm[ad(KCH_BASE + 2 * j)]);
                cyc++;
                for (int i = 0; i < n; i++) begin
                    c = int'(mm[ad(CCNT_BASE + 2 * i)]);
                    if (c > MAX_CH) c = MAX_CH;
                    cyc++;
                    found = 1'b0;
                    exam  = 0;
                    for (int k = 0; k < c && !found; k++) begin
                        exam++;
                        if (int'(mm[ad(CID_BASE + NB_STRIDE * i + 2 * k)]) == kch) found = 1'b1;
                    end
                    cyc += exam;
                    if (!found) begin
                        cyc++;
                        if (c >= MAX_CH) begin
                            ovf = 1'b1;
                        end else begin
                            la = ad(CID_BASE + NB_STRIDE * i + 2 * c);
                            e = '{is_done: 1'b0, addr: la, data: kch, ovf: 1'b0, lat: 0};
                            sb.push_back(e);
                            mm[la] = 16'(kch);
                            ca = ad(CCNT_BASE + 2 * i);
                            e = '{is_done: 1'b0, addr: ca, data: c + 1, ovf: 1'b0, lat: 0};
                            sb.push_back(e);
                            mm[ca] = 16'(c + 1);
                            cyc++;
                        end
                    end
                    cyc++;
                end
            end
        end
        cyc++;
        e = '{is_done: 1'b1, addr: 0, data: 0, ovf: ovf, lat: cyc};
        sb.push_back(e);
    endtask

    task automatic clear_case();
        c_ncnt = 0;
        c_kcnt = 0;
        for (int j = 0; j < 4; j++) c_kch[j] = 0;
        for (int i = 0; i < MAX_NB; i++) begin
            c_cnt[i] = 0;
            for (int k = 0; k < MAX_CH; k++) c_list[i][k] = 'hEEEE;
        end
    endtask

    task automatic load_case();
        for (int a = 0; a < MEM_N; a++) img[a] = 16'($urandom);
        img[NCNT_ADDR] = 16'(c_ncnt);
        img[KCNT_ADDR] = 16'(c_kcnt);
        for (int j = 0; j < 4; j++) img[ad(KCH_BASE + 2 * j)] = 16'(c_kch[j]);
        for (int i = 0; i < MAX_NB; i++) begin
            img[ad(CCNT_BASE + 2 * i)] = 16'(c_cnt[i]);
            for (int k = 0; k < MAX_CH; k++) img[ad(CID_BASE + NB_STRIDE * i + 2 * k)] = 16'(c_list[i][k]);
        end
        @(negedge clock);
        load_req = 1'b1;
        @(negedge clock);
        load_req = 1'b0;
    endtask

    task automatic run_case(input string name);
        int dc;
        bit seen;
        $display("case %s: ncnt=%0d kcnt=%0d", name, c_ncnt, c_kcnt);
        model_push();
        @(negedge clock);
        bus.en     = 1'b1;
        bus.start  = 1'b1;
        start_mark = cyc_cnt;
        dc         = done_count;
        @(negedge clock);
        bus.start = 1'b0;
        check("busy_after_start", int'(bus.busy), 1);
        @(negedge clock);
        bus.start = 1'b1;              // must be ignored while busy
        @(negedge clock);
        bus.start = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 4000; t++) begin
            if (done_count != dc) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within 4000 cycles, expected a done pulse");
            sb.delete();
            bus.en = 1'b0;
            repeat (2) @(negedge clock);
            bus.en = 1'b1;
        end
        @(negedge clock);
        check("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en    = 1'b0;
        bus.start = 1'b0;
        nrst      = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_address", int'(bus.address), 0);
        check("reset_wr_en", int'(bus.wr_en), 0);
        check("reset_data_out", int'(bus.data_out), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_overflow", int'(bus.overflow), 0);
        nrst = 1'b1;

        // Single missing ID in neighbour 1.
        clear_case();
        c_ncnt = 2; c_kcnt = 1; c_kch[0] = 5;
        c_cnt[0] = 1; c_list[0][0] = 5;
        c_cnt[1] = 1; c_list[1][0] = 3;
        load_case();
        run_case("single_append");

        // Every list already holds every known CH.
        clear_case();
        c_ncnt = 3; c_kcnt = 2; c_kch[0] = 4; c_kch[1] = 9;
        c_cnt[0] = 2; c_list[0][0] = 4; c_list[0][1] = 9;
        c_cnt[1] = 3; c_list[1][0] = 9; c_list[1][1] = 4; c_list[1][2] = 1;
        c_cnt[2] = 3; c_list[2][0] = 2; c_list[2][1] = 9; c_list[2][2] = 4;
        load_case();
        run_case("all_present");

        clear_case();
        c_ncnt = 0; c_kcnt = 2; c_kch[0] = 1; c_kch[1] = 2;
        load_case();
        run_case("no_neighbours");

        // Full list 0 overflows, list 1 still receives the ID.
        clear_case();
        c_ncnt = 2; c_kcnt = 1; c_kch[0] = 'h20;
        c_cnt[0] = 8;
        for (int k = 0; k < MAX_CH; k++) c_list[0][k] = k + 1;
        c_cnt[1] = 1; c_list[1][0] = 1;
        load_case();
        run_case("overflow");

        clear_case();
        c_ncnt = 1; c_kcnt = 2; c_kch[0] = 7; c_kch[1] = 7;
        c_cnt[0] = 1; c_list[0][0] = 1;
        load_case();
        run_case("duplicate_kch");

        clear_case();
        c_ncnt = 1; c_kcnt = 1; c_kch[0] = 3;
        load_case();
        run_case("empty_list");

        // Abort during the first chIDs read, then restart.
        clear_case();
        c_ncnt = 2; c_kcnt = 1; c_kch[0] = 9;
        c_cnt[0] = 3; c_list[0][0] = 1; c_list[0][1] = 2; c_list[0][2] = 3;
        c_cnt[1] = 1; c_list[1][0] = 4;
        load_case();
        @(negedge clock);
        bus.en = 1'b1; bus.start = 1'b1; start_mark = cyc_cnt;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (4) @(negedge clock);
        check("abort_at_cid_addr", int'(bus.address), CID_BASE);
        bus.en = 1'b0;
        @(negedge clock);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_wr_en", int'(bus.wr_en), 0);
        check("abort_overflow", int'(bus.overflow), 0);
        repeat (8) @(negedge clock);
        run_case("restart_after_abort");

        // Reset while a write is on the bus.
        clear_case();
        c_ncnt = 1; c_kcnt = 1; c_kch[0] = 6;
        c_cnt[0] = 2; c_list[0][0] = 1; c_list[0][1] = 2;
        load_case();
        model_push();
        @(negedge clock);
        bus.en = 1'b1; bus.start = 1'b1; start_mark = cyc_cnt;
        @(negedge clock);
        bus.start = 1'b0;
        for (int t = 0; t < 200 && bus.wr_en !== 1'b1; t++) @(negedge clock);
        check("pre_reset_wr_en", int'(bus.wr_en), 1);
        nrst = 1'b0;
        @(negedge clock);
        check("reset_mid_wr_en", int'(bus.wr_en), 0);
        check("reset_mid_busy", int'(bus.busy), 0);
        sb.delete();
        nrst = 1'b1;

        for (int r = 0; r < 30; r++) begin
            clear_case();
            c_ncnt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(17, 20)) : int'($urandom_range(0, 6));
            c_kcnt = int'($urandom_range(0, 4));
            for (int j = 0; j < 4; j++) c_kch[j] = int'($urandom_range(1, 6));
            for (int i = 0; i < MAX_NB; i++) begin
                c_cnt[i] = int'($urandom_range(0, 10));
                for (int k = 0; k < MAX_CH; k++) c_list[i][k] = int'($urandom_range(1, 6));
            end
            load_case();
            run_case($sformatf("random_%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
